execute_stage_mdu: RTL and testbench
====================================

# execute_stage_mdu

Parametrised execute stage for the pipelined MIPS core. It sits between the ID/EX and EX/MEM boundaries and contains the operand-forwarding muxes, a width-generic ALU, and a background iterative unsigned multiply/divide unit with HI/LO registers. It owns the EX/MEM pipeline register, so all results are registered. It raises a stall request when an instruction depends on a multiply/divide that has not finished.

## Interface
- DATA_W, 32: datapath width. Must be even and ≥ 8.
- REG_W, 5: register-address width.
- SH_W, $clog2(DATA_W): shift-amount width.
- i_clk, in, 1: clock. Every register updates on its rising edge.
- i_reset, in, 1: asynchronous, active-high reset.
- i_halt, in, 1: freezes all state, including the MDU counter.
- i_valid, in, 1: an instruction is present in EX.
- i_alu_ctl, in, 5: decoded operation (see Operation).
- i_alu_src, in, 1: selects operand B. 0 = forwarded RB; 1 = i_inmediate.
- i_reg_dest, in, 1: selects the destination. 0 = i_rt; 1 = i_rd.
- i_mem_read, i_mem_write, i_mem_unsigned, in, 1 each: MEM-stage control.
- i_mem_data_width, in, 2: MEM-stage control.
- i_wb_mem_to_reg, i_wb_reg_write, in, 1 each: WB-stage control.
- i_RA, i_RB, i_inmediate, in, DATA_W each: operands from ID.
- i_rt, i_rd, in, REG_W each: register fields.
- i_shamt, in, SH_W: shift amount.
- i_forward_A, i_forward_B, in, 2 each: forwarding select. 00 = ID value; 01 = i_WB_data; 10 = i_MEM_ALU_result; 11 = same as 00.
- i_MEM_ALU_result, i_WB_data, in, DATA_W each: forwarded values.
- o_stall, out, 1: combinational. Hold ID/EX and earlier stages.
- o_valid, out, 1: the EX/MEM slot holds a real instruction.
- o_ALU_result, o_data_to_write, out, DATA_W each: registered results.
- o_reg_dest, out, REG_W: registered destination.
- o_mem_read, o_mem_write, o_mem_unsigned, o_mem_data_width, o_wb_mem_to_reg, o_wb_reg_write, out: registered copies of the corresponding inputs.

## Operation
- Forwarded operands: A = mux(i_forward_A). FB = mux(i_forward_B). B = i_alu_src ? i_inmediate : FB.
- o_data_to_write = FB.
- Destination = i_reg_dest ? i_rd : i_rt.
- ALU codes:
  - 0 ADD, 1 SUB: wrap modulo 2^DATA_W; no overflow trap.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU: result is 1 or 0, zero-extended.
  - 8 SLL, 9 SRL, 10 SRA: shift B by i_shamt.
  - 11 SLLV, 13 SRLV, 14 SRAV: shift B by A[SH_W-1:0].
  - 12 LUI: B << (DATA_W/2).
  - 16 MULTU, 17 DIVU: start the MDU with A, B. Result field = 0.
  - 18 MFHI, 19 MFLO: result = HI or LO.
  - All other codes: result 0.
- MDU:
  - Radix-2 iterative unit: shift-add multiplier, restoring divider.
  - 1 bit per cycle; DATA_W iterations.
  - MULTU: {HI,LO} = A*B, 2·DATA_W-bit product.
  - DIVU: LO = A/B, HI = A%B.
  - DIVU with B = 0: LO = all ones, HI = A. No exception.
  - busy = (count != 0).
  - Start: count = DATA_W at the accepting edge.
  - Each non-halted edge decrements count. HI/LO commit on the edge where count goes 1→0.
- Stall rule: o_stall = i_valid & busy & (i_alu_ctl ∈ {16,17,18,19}).
- Accept: an instruction is accepted when i_valid & !o_stall & !i_halt.
  - Accepted: the EX/MEM register loads its results and o_valid = 1.
  - Stalled, not halted: a bubble is loaded. o_valid = 0; every control output = 0; data outputs = 0.
  - Other instructions proceed while the MDU is busy.
- i_valid = 0 (not halted): a bubble is loaded.
- i_halt = 1: EX/MEM register, HI, LO, count and MDU datapath all hold. o_stall is still evaluated.

## Timing
- Reset: every output, HI, LO, count and the MDU datapath = 0. o_stall = 0.
- Reset during an MDU operation aborts it; HI and LO remain 0.
- Non-MDU operations: 1-cycle latency. Inputs in cycle T appear on outputs after edge T.
- MULTU/DIVU accepted at edge T: HI/LO are valid after edge T+DATA_W.
  - MFHI/MFLO in the cycle immediately after sees o_stall = 1 for DATA_W cycles, then is accepted.
- Back-to-back MULTU while busy: the second one stalls until count = 0, then starts.
- HI/LO commit and a new MDU start cannot coincide, because a start requires busy = 0.

## Test plan
- Reset mid-MULTU (count = 10) → all outputs 0 and o_stall = 0 immediately. MFLO afterwards returns 0.
- ADD with A = 0x7FFFFFFF, B = 1, forward_A = 10, i_MEM_ALU_result = 5 → o_ALU_result = 6 after one edge. o_valid = 1 and control outputs are copied through.
- SRA with B = 0x80000000, shamt = 4 → 0xF8000000. SLTU with 1 vs 0xFFFFFFFF → 1. LUI with imm = 0x1234 → 0x12340000.
- MULTU 0xFFFFFFFF × 2, then MFHI next cycle:
  - o_stall is high for exactly 32 cycles; bubbles are emitted meanwhile.
  - MFHI then yields 1; MFLO yields 0xFFFFFFFE.
  - An ADD issued while busy passes without stall.
- DIVU 100 / 7 → LO = 14, HI = 2. DIVU 9 / 0 → LO = 0xFFFFFFFF, HI = 9.
- i_halt held for 5 cycles during a DIVU → outputs and count frozen; completion is delayed by exactly 5 cycles.
- Repeat one case with DATA_W = 16: MULTU 0xFFFF × 0xFFFF → HI = 0xFFFE, LO = 0x0001, after 16 stall cycles.

Source files
------------

// File: rtl/execute_stage_mdu.sv
// MIPS execute stage: operand forwarding, ALU, background radix-2 multiply/divide
// unit with HI/LO, and the EX/MEM pipeline register.
module execute_stage_mdu #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_halt,
    input  logic              i_valid,
    input  logic [4:0]        i_alu_ctl,
    input  logic              i_alu_src,
    input  logic              i_reg_dest,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_unsigned,
    input  logic [1:0]        i_mem_data_width,
    input  logic              i_wb_mem_to_reg,
    input  logic              i_wb_reg_write,
    input  logic [DATA_W-1:0] i_RA,
    input  logic [DATA_W-1:0] i_RB,
    input  logic [DATA_W-1:0] i_inmediate,
    input  logic [REG_W-1:0]  i_rt,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [SH_W-1:0]   i_shamt,
    input  logic [1:0]        i_forward_A,
    input  logic [1:0]        i_forward_B,
    input  logic [DATA_W-1:0] i_MEM_ALU_result,
    input  logic [DATA_W-1:0] i_WB_data,
    output logic              o_stall,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_ALU_result,
    output logic [DATA_W-1:0] o_data_to_write,
    output logic [REG_W-1:0]  o_reg_dest,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_mem_unsigned,
    output logic [1:0]        o_mem_data_width,
    output logic              o_wb_mem_to_reg,
    output logic              o_wb_reg_write
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SLL   = 5'd8;
    localparam logic [4:0] OP_SRL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_SLLV  = 5'd11;
    localparam logic [4:0] OP_LUI   = 5'd12;
    localparam logic [4:0] OP_SRLV  = 5'd13;
    localparam logic [4:0] OP_SRAV  = 5'd14;
    localparam logic [4:0] OP_MULTU = 5'd16;
    localparam logic [4:0] OP_DIVU  = 5'd17;
    localparam logic [4:0] OP_MFHI  = 5'd18;
    localparam logic [4:0] OP_MFLO  = 5'd19;

    logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_result;
    logic [SH_W-1:0]   var_sh;
    logic              lt_signed, lt_unsigned;
    logic              busy, is_mdu_op, is_mdu_start, accept;

    logic [CNT_W-1:0]  count_reg;
    logic              is_div_reg;
    logic [DATA_W-1:0] divisor_reg, p_hi_reg, p_lo_reg, hi_reg, lo_reg;
    logic [DATA_W-1:0] step_hi_next, step_lo_next;
    logic [DATA_W:0]   mul_sum, rem_shift;
    logic              rem_ge;

    always_comb begin
        case (i_forward_A)
            2'b01:   op_a = i_WB_data;
            2'b10:   op_a = i_MEM_ALU_result;
            default: op_a = i_RA;
        endcase
        case (i_forward_B)
            2'b01:   fwd_b = i_WB_data;
            2'b10:   fwd_b = i_MEM_ALU_result;
            default: fwd_b = i_RB;
        endcase
    end

    assign op_b        = i_alu_src ? i_inmediate : fwd_b;
    assign var_sh      = op_a[SH_W-1:0];
    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;

    always_comb begin
        alu_result = '0;
        case (i_alu_ctl)
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_NOR:  alu_result = ~(op_a | op_b);
            OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, lt_signed};
            OP_SLTU: alu_result = {{(DATA_W-1){1'b0}}, lt_unsigned};
            OP_SLL:  alu_result = op_b << i_shamt;
            OP_SRL:  alu_result = op_b >> i_shamt;
            OP_SRA:  alu_result = $unsigned($signed(op_b) >>> i_shamt);
            OP_SLLV: alu_result = op_b << var_sh;
            OP_LUI:  alu_result = op_b << (DATA_W / 2);
            OP_SRLV: alu_result = op_b >> var_sh;
            OP_SRAV: alu_result = $unsigned($signed(op_b) >>> var_sh);
            OP_MFHI: alu_result = hi_reg;
            OP_MFLO: alu_result = lo_reg;
            default: alu_result = '0;
        endcase
    end

    // Codes 16..19 all touch the MDU and must wait while it is running.
    assign is_mdu_op    = (i_alu_ctl[4:2] == 3'b100);
    assign is_mdu_start = (i_alu_ctl == OP_MULTU) || (i_alu_ctl == OP_DIVU);
    assign busy         = (count_reg != '0);
    assign o_stall      = i_valid & busy & is_mdu_op;
    assign accept       = i_valid & ~o_stall & ~i_halt;

    // Multiply: add multiplicand when LSB of multiplier set, shift {hi,lo} right.
    assign mul_sum = {1'b0, p_hi_reg} + (p_lo_reg[0] ? {1'b0, divisor_reg} : '0);
    // Divide: shift next dividend bit into remainder, subtract if it fits.
    assign rem_shift = {p_hi_reg, p_lo_reg[DATA_W-1]};
    assign rem_ge    = rem_shift >= {1'b0, divisor_reg};

    always_comb begin
        if (is_div_reg) begin
            step_hi_next = rem_ge ? (rem_shift[DATA_W-1:0] - divisor_reg) : rem_shift[DATA_W-1:0];
            step_lo_next = {p_lo_reg[DATA_W-2:0], rem_ge};
        end else begin
            step_hi_next = mul_sum[DATA_W:1];
            step_lo_next = {mul_sum[0], p_lo_reg[DATA_W-1:1]};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_reg   <= '0;
            is_div_reg  <= 1'b0;
            divisor_reg <= '0;
            p_hi_reg    <= '0;
            p_lo_reg    <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else if (!i_halt) begin
            if (accept && is_mdu_start) begin
                count_reg   <= CNT_W'(DATA_W);
                is_div_reg  <= (i_alu_ctl == OP_DIVU);
                divisor_reg <= op_b;
                p_hi_reg    <= '0;
                p_lo_reg    <= op_a;
            end else if (busy) begin
                count_reg <= count_reg - CNT_W'(1);
                p_hi_reg  <= step_hi_next;
                p_lo_reg  <= step_lo_next;
                if (count_reg == CNT_W'(1)) begin
                    hi_reg <= step_hi_next;
                    lo_reg <= step_lo_next;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid          <= 1'b0;
            o_ALU_result     <= '0;
            o_data_to_write  <= '0;
            o_reg_dest       <= '0;
            o_mem_read       <= 1'b0;
            o_mem_write      <= 1'b0;
            o_mem_unsigned   <= 1'b0;
            o_mem_data_width <= 2'b00;
            o_wb_mem_to_reg  <= 1'b0;
            o_wb_reg_write   <= 1'b0;
        end else if (!i_halt) begin
            // Anything not accepted becomes an all-zero bubble.
            o_valid          <= accept;
            o_ALU_result     <= accept ? alu_result : '0;
            o_data_to_write  <= accept ? fwd_b : '0;
            o_reg_dest       <= accept ? (i_reg_dest ? i_rd : i_rt) : '0;
            o_mem_read       <= accept & i_mem_read;
            o_mem_write      <= accept & i_mem_write;
            o_mem_unsigned   <= accept & i_mem_unsigned;
            o_mem_data_width <= accept ? i_mem_data_width : 2'b00;
            o_wb_mem_to_reg  <= accept & i_wb_mem_to_reg;
            o_wb_reg_write   <= accept & i_wb_reg_write;
        end
    end
endmodule

// File: tb/tb_execute_stage_mdu.sv
// Scoreboard bench for execute_stage_mdu: driver pushes model results, a negedge
// monitor pops and compares every presented EX/MEM slot.
module tb_execute_stage_mdu;
    localparam int W = 32;

    typedef struct packed {
        logic [4:0]  ctl;
        logic        alu_src;
        logic        reg_dest;
        logic [6:0]  ctrl;
        logic [31:0] ra, rb, imm, mem_res, wb_data;
        logic [4:0]  rt, rd, shamt;
        logic [1:0]  fa, fb;
    } instr_t;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] dtw;
        logic [4:0]  dest;
        logic [6:0]  ctrl;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_reset, i_halt, i_valid, i_alu_src, i_reg_dest;
    logic [4:0]  i_alu_ctl, i_rt, i_rd, i_shamt;
    logic        i_mem_read, i_mem_write, i_mem_unsigned, i_wb_mem_to_reg, i_wb_reg_write;
    logic [1:0]  i_mem_data_width, i_forward_A, i_forward_B;
    logic [31:0] i_RA, i_RB, i_inmediate, i_MEM_ALU_result, i_WB_data;
    logic        o_stall, o_valid, o_mem_read, o_mem_write, o_mem_unsigned, o_wb_mem_to_reg, o_wb_reg_write;
    logic [1:0]  o_mem_data_width;
    logic [31:0] o_ALU_result, o_data_to_write;
    logic [4:0]  o_reg_dest;

    execute_stage_mdu #(.DATA_W(32), .REG_W(5)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_halt(i_halt), .i_valid(i_valid),
        .i_alu_ctl(i_alu_ctl), .i_alu_src(i_alu_src), .i_reg_dest(i_reg_dest),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_unsigned(i_mem_unsigned),
        .i_mem_data_width(i_mem_data_width), .i_wb_mem_to_reg(i_wb_mem_to_reg),
        .i_wb_reg_write(i_wb_reg_write), .i_RA(i_RA), .i_RB(i_RB), .i_inmediate(i_inmediate),
        .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt), .i_forward_A(i_forward_A),
        .i_forward_B(i_forward_B), .i_MEM_ALU_result(i_MEM_ALU_result), .i_WB_data(i_WB_data),
        .o_stall(o_stall), .o_valid(o_valid), .o_ALU_result(o_ALU_result),
        .o_data_to_write(o_data_to_write), .o_reg_dest(o_reg_dest), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_mem_unsigned(o_mem_unsigned),
        .o_mem_data_width(o_mem_data_width), .o_wb_mem_to_reg(o_wb_mem_to_reg),
        .o_wb_reg_write(o_wb_reg_write)
    );

    // Narrow instance: only the MULTU/MFHI/MFLO path is exercised.
    logic        v16, stall16, valid16, z16_1, z16_2, z16_3, z16_4, z16_5;
    logic [4:0]  ctl16, dest16;
    logic [15:0] ra16, rb16, res16, dtw16;
    logic [1:0]  zw16;
    execute_stage_mdu #(.DATA_W(16), .REG_W(5)) dut16 (
        .i_clk(clk), .i_reset(i_reset), .i_halt(1'b0), .i_valid(v16),
        .i_alu_ctl(ctl16), .i_alu_src(1'b0), .i_reg_dest(1'b0),
        .i_mem_read(1'b0), .i_mem_write(1'b0), .i_mem_unsigned(1'b0),
        .i_mem_data_width(2'b00), .i_wb_mem_to_reg(1'b0), .i_wb_reg_write(1'b0),
        .i_RA(ra16), .i_RB(rb16), .i_inmediate(16'h0), .i_rt(5'd0), .i_rd(5'd0),
        .i_shamt(4'd0), .i_forward_A(2'b00), .i_forward_B(2'b00),
        .i_MEM_ALU_result(16'h0), .i_WB_data(16'h0),
        .o_stall(stall16), .o_valid(valid16), .o_ALU_result(res16), .o_data_to_write(dtw16),
        .o_reg_dest(dest16), .o_mem_read(z16_1), .o_mem_write(z16_2), .o_mem_unsigned(z16_3),
        .o_mem_data_width(zw16), .o_wb_mem_to_reg(z16_4), .o_wb_reg_write(z16_5)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        q[$];
    int          busy_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          stalls_seen = 0;
    logic        halted_last = 1'b0;
    exp_t        last_exp = '0;
    logic        last_valid = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] id_v,
                                         input logic [31:0] wb, input logic [31:0] mem);
        return (f == 2'd1) ? wb : (f == 2'd2) ? mem : id_v;
    endfunction

    // Behavioural reference for the EX/MEM slot of one accepted instruction.
    function automatic exp_t model(input instr_t x);
        exp_t e;
        logic [31:0] a, fb, b, r;
        a  = pick(x.fa, x.ra, x.wb_data, x.mem_res);
        fb = pick(x.fb, x.rb, x.wb_data, x.mem_res);
        b  = x.alu_src ? x.imm : fb;
        case (x.ctl)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~(a | b);
            5'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:  r = (a < b) ? 32'd1 : 32'd0;
            5'd8:  r = b << x.shamt;
            5'd9:  r = b >> x.shamt;
            5'd10: r = $unsigned($signed(b) >>> x.shamt);
            5'd11: r = b << a[4:0];
            5'd12: r = {b[15:0], 16'h0000};
            5'd13: r = b >> a[4:0];
            5'd14: r = $unsigned($signed(b) >>> a[4:0]);
            5'd18: r = m_hi;
            5'd19: r = m_lo;
            default: r = 32'd0;
        endcase
        e.res  = r;
        e.dtw  = fb;
        e.dest = x.reg_dest ? x.rd : x.rt;
        e.ctrl = x.ctrl;
        return e;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t x;
        x.ctl = 5'($urandom_range(0, 15));
        x.alu_src = 1'($urandom); x.reg_dest = 1'($urandom);
        x.ctrl = 7'($urandom);
        x.ra = $urandom; x.rb = $urandom; x.imm = $urandom;
        x.mem_res = $urandom; x.wb_data = $urandom;
        x.rt = 5'($urandom); x.rd = 5'($urandom); x.shamt = 5'($urandom);
        x.fa = 2'($urandom); x.fb = 2'($urandom);
        return x;
    endfunction

    function automatic instr_t dir(input logic [4:0] ctl, input logic [31:0] ra, input logic [31:0] rb);
        instr_t x;
        x = rnd_instr();
        x.ctl = ctl; x.ra = ra; x.rb = rb; x.alu_src = 1'b0; x.fa = 2'd0; x.fb = 2'd0;
        return x;
    endfunction

    // One clock cycle of stimulus; the model advances at the edge.
    task automatic step(input logic v, input instr_t x, input logic h, output logic acc);
        logic exp_stall;
        logic [31:0] a, b;
        i_valid = v; i_halt = h; i_alu_ctl = x.ctl; i_alu_src = x.alu_src; i_reg_dest = x.reg_dest;
        {i_mem_read, i_mem_write, i_mem_unsigned, i_mem_data_width, i_wb_mem_to_reg, i_wb_reg_write} = x.ctrl;
        i_RA = x.ra; i_RB = x.rb; i_inmediate = x.imm; i_MEM_ALU_result = x.mem_res; i_WB_data = x.wb_data;
        i_rt = x.rt; i_rd = x.rd; i_shamt = x.shamt; i_forward_A = x.fa; i_forward_B = x.fb;
        @(negedge clk);
        exp_stall = v && (busy_left > 0) && (x.ctl >= 5'd16) && (x.ctl <= 5'd19);
        check("stall", {127'd0, o_stall}, {127'd0, exp_stall});
        if (o_stall) stalls_seen++;
        @(posedge clk);
        acc = v && !exp_stall && !h;
        if (!h) begin
            if (busy_left > 0) busy_left--;
            if (acc) begin
                q.push_back(model(x));
                a = pick(x.fa, x.ra, x.wb_data, x.mem_res);
                b = x.alu_src ? x.imm : pick(x.fb, x.rb, x.wb_data, x.mem_res);
                if (x.ctl == 5'd16) begin
                    {m_hi, m_lo} = 64'(a) * 64'(b);
                    busy_left = W;
                end else if (x.ctl == 5'd17) begin
                    if (b == 0) begin m_lo = '1; m_hi = a; end
                    else begin m_lo = a / b; m_hi = a % b; end
                    busy_left = W;
                end
            end
        end
        #1;
    endtask

    task automatic issue(input instr_t x);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) step(1'b1, x, 1'b0, acc);
        if (!acc) check("issue_timeout", 128'd0, 128'd1);
    endtask

    task automatic bubble(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, rnd_instr(), 1'b0, acc);
    endtask

    always @(posedge clk) halted_last <= i_halt;

    // Monitor: compares each presented slot against the scoreboard.
    always @(negedge clk) begin
        logic [76:0] act_v, exp_v;
        exp_t e;
        act_v = {o_valid, o_ALU_result, o_data_to_write, o_reg_dest, o_mem_read, o_mem_write,
                 o_mem_unsigned, o_mem_data_width, o_wb_mem_to_reg, o_wb_reg_write};
        if (i_reset) begin
            last_exp = '0; last_valid = 1'b0;
        end else if (halted_last) begin
            check("held_slot", 128'(act_v), 128'({last_valid, last_exp}));
        end else if (o_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 128'(act_v), 128'd0);
            end else begin
                e = q.pop_front();
                exp_v = {1'b1, e};
                check("slot", 128'(act_v), 128'(exp_v));
                last_exp = e; last_valid = 1'b1;
            end
        end else begin
            check("bubble", 128'(act_v), 128'd0);
            last_exp = '0; last_valid = 1'b0;
        end
    end

    initial begin
        instr_t x;
        logic acc;
        int n;
        i_reset = 1'b1; i_halt = 1'b0; i_valid = 1'b0; i_alu_ctl = '0; i_alu_src = 1'b0;
        i_reg_dest = 1'b0; i_rt = '0; i_rd = '0; i_shamt = '0; i_mem_read = 1'b0;
        i_mem_write = 1'b0; i_mem_unsigned = 1'b0; i_wb_mem_to_reg = 1'b0; i_wb_reg_write = 1'b0;
        i_mem_data_width = '0; i_forward_A = '0; i_forward_B = '0; i_RA = '0; i_RB = '0;
        i_inmediate = '0; i_MEM_ALU_result = '0; i_WB_data = '0;
        v16 = 1'b0; ctl16 = '0; ra16 = '0; rb16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {51'd0, o_valid, o_ALU_result, o_data_to_write, o_reg_dest, o_stall}, 128'd0);
        i_reset = 1'b0;

        // Forwarded ADD wraps nothing: 5 + 1.
        x = dir(5'd0, 32'h7FFF_FFFF, 32'd1); x.fa = 2'd2; x.mem_res = 32'd5; x.ctrl = 7'b1010111;
        issue(x);
        x = dir(5'd10, 32'd0, 32'h8000_0000); x.shamt = 5'd4; issue(x);
        x = dir(5'd7, 32'd1, 32'hFFFF_FFFF); issue(x);
        x = dir(5'd12, 32'd0, 32'd0); x.alu_src = 1'b1; x.imm = 32'h0000_1234; issue(x);

        // MULTU followed immediately by MFHI stalls for W cycles.
        issue(dir(5'd16, 32'hFFFF_FFFF, 32'd2));
        stalls_seen = 0;
        issue(dir(5'd18, 32'd0, 32'd0));
        check("multu_stall_cycles", 128'(stalls_seen), 128'd32);
        issue(dir(5'd19, 32'd0, 32'd0));

        // A non-MDU op overlaps a running multiply.
        issue(dir(5'd16, 32'h1234_5678, 32'h9ABC_DEF0));
        stalls_seen = 0;
        issue(dir(5'd0, 32'd3, 32'd4));
        check("add_while_busy_stalls", 128'(stalls_seen), 128'd0);
        issue(dir(5'd19, 32'd0, 32'd0));
        issue(dir(5'd18, 32'd0, 32'd0));

        issue(dir(5'd17, 32'd100, 32'd7));
        issue(dir(5'd19, 32'd0, 32'd0));
        issue(dir(5'd18, 32'd0, 32'd0));
        issue(dir(5'd17, 32'd9, 32'd0));
        issue(dir(5'd19, 32'd0, 32'd0));
        issue(dir(5'd18, 32'd0, 32'd0));

        // Halt for 5 cycles during a DIVU delays completion by 5.
        issue(dir(5'd17, 32'd1000, 32'd13));
        stalls_seen = 0;
        for (int k = 0; k < 5; k++) step(1'b1, dir(5'd19, 32'd0, 32'd0), 1'b1, acc);
        issue(dir(5'd19, 32'd0, 32'd0));
        check("halt_delay_stalls", 128'(stalls_seen), 128'd37);

        // Reset with 10 multiply cycles remaining.
        issue(dir(5'd16, 32'hDEAD_BEEF, 32'h0000_0123));
        bubble(21);
        issue(dir(5'd0, 32'd40, 32'd2));
        i_valid = 1'b1; i_alu_ctl = 5'd19; i_halt = 1'b0;
        #1;
        check("stall_before_reset", {127'd0, o_stall}, 128'd1);
        i_reset = 1'b1;
        #1;
        check("reset_mid_op", {51'd0, o_valid, o_ALU_result, o_data_to_write, o_reg_dest, o_stall}, 128'd0);
        q.delete(); busy_left = 0; m_hi = '0; m_lo = '0;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        stalls_seen = 0;
        issue(dir(5'd19, 32'd0, 32'd0));
        issue(dir(5'd18, 32'd0, 32'd0));
        check("after_reset_stalls", 128'(stalls_seen), 128'd0);

        // Randomised traffic with bubbles, halts and occasional MDU work.
        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(0, 99);
            x = rnd_instr();
            if (n < 5) begin
                x.ctl = ($urandom_range(0, 1) == 0) ? 5'd16 : 5'd17;
                if ($urandom_range(0, 7) == 0) begin x.fb = 2'd0; x.alu_src = 1'b0; x.rb = 32'd0; end
            end else if (n < 14) x.ctl = ($urandom_range(0, 1) == 0) ? 5'd18 : 5'd19;
            else if (n < 20) x.ctl = 5'($urandom_range(20, 31));
            else if (n < 22) x.ctl = 5'd15;
            if ($urandom_range(0, 9) == 0) bubble($urandom_range(1, 2));
            if ($urandom_range(0, 9) == 0)
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(1'($urandom), rnd_instr(), 1'b1, acc);
            issue(x);
        end
        bubble(3);

        // 16-bit instance: 0xFFFF * 0xFFFF.
        v16 = 1'b1; ctl16 = 5'd16; ra16 = 16'hFFFF; rb16 = 16'hFFFF;
        @(posedge clk);
        #1;
        ctl16 = 5'd18;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall16) break;
            n++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check("w16_stall_cycles", 128'(n), 128'd16);
        check("w16_mfhi", {111'd0, valid16, res16}, {111'd0, 1'b1, 16'hFFFE});
        ctl16 = 5'd19;
        @(negedge clk);
        check("w16_mflo_stall", {127'd0, stall16}, 128'd0);
        @(posedge clk);
        #1;
        check("w16_mflo", {111'd0, valid16, res16}, {111'd0, 1'b1, 16'h0001});
        v16 = 1'b0;

        check("scoreboard_empty", 128'(q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
